// File: rtl/count_capture_pkg.sv
// count_capture_pkg: shared defaults and sizing helper for the count capture block
package count_capture_pkg;

    localparam int DefaultWidth = 8;
    localparam int DefaultDepth = 4;

    // Bits needed to hold an occupancy of 0..depth inclusive
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/count_capture_if.sv
// count_capture_if: valid/ready output stream carrying captured count values
interface count_capture_if
    import count_capture_pkg::*;
#(
    parameter int Width = DefaultWidth
);

    logic             out_valid;
    logic             out_ready;
    logic [Width-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/count_capture_sync_fifo.sv
// sync_fifo: power-of-two circular buffer owning pointers, occupancy and storage
module sync_fifo
    import count_capture_pkg::*;
#(
    parameter int Width = DefaultWidth,
    parameter int Depth = DefaultDepth
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [Width-1:0]            wr_data,
    output logic [Width-1:0]            rd_data,
    output logic [level_w(Depth)-1:0]   level,
    output logic                        full,
    output logic                        empty
);

    localparam int LW = level_w(Depth);
    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = level == LW'(Depth);
    assign empty   = level == '0;
    assign do_pop  = pop & ~empty;
    // A full buffer still accepts a write when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage is not reset; stale entries stay hidden behind the occupancy count
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally since Depth is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            level <= (do_push && !do_pop) ? level + LW'(1) :
                     (!do_push && do_pop) ? level - LW'(1) : level;
        end
    end

endmodule

// File: rtl/count_capture.sv
// count_capture: snapshots count on each rising edge of event_in into a FIFO
module count_capture
    import count_capture_pkg::*;
#(
    parameter int Width = DefaultWidth,
    parameter int Depth = DefaultDepth
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [Width-1:0]            count,
    input  logic                        event_in,
    count_capture_if.master             out_if,
    output logic [level_w(Depth)-1:0]   level,
    output logic                        overflow
);

    logic             prev_event;
    logic             capture;
    logic             pop;
    logic             full;
    logic             empty;
    logic [Width-1:0] rd_data;

    assign capture = event_in & ~prev_event;
    assign pop     = out_if.out_valid & out_if.out_ready;

    // Resetting to 1 keeps an event already high through reset from capturing
    always_ff @(posedge clk) begin
        if (reset) prev_event <= 1'b1;
        else prev_event <= event_in;
    end

    // Sticky: only a capture that finds no room and no departing head is lost
    always_ff @(posedge clk) begin
        if (reset) overflow <= 1'b0;
        else if (capture && full && !pop) overflow <= 1'b1;
    end

    sync_fifo #(.Width(Width), .Depth(Depth)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (capture),
        .pop     (pop),
        .wr_data (count),
        .rd_data (rd_data),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    assign out_if.out_valid = ~empty;
    assign out_if.out_data  = out_if.out_valid ? rd_data : '0;

endmodule

// File: doc/count_capture.md
COUNT_CAPTURE -- requirements
Module: count_capture

Interface
REQ-001 Parameter Width, default 8: bit width of the sampled counter value and of the output data.
REQ-002 Parameter Depth, default 4: number of capture FIFO entries; legal values are powers of two, 2..16.
REQ-003 clk  input  1: clock; all state updates on the rising edge.
REQ-004 reset  input  1: synchronous reset, active high.
REQ-005 count  input  Width: free-running counter value from the upstream counter stage.
REQ-006 event_in  input  1: synchronous event strobe, level; a rising edge triggers a capture.
REQ-007 out_ready  input  1: downstream ready to accept the head entry.
REQ-008 out_valid  output  1: head entry available.
REQ-009 out_data  output  Width: captured count value at the FIFO head.
REQ-010 level  output  $clog2(Depth+1): number of occupied entries.
REQ-011 overflow  output  1: sticky flag; a capture was dropped because the FIFO was full.

Function
REQ-012 The block SHALL register event_in into prev_event every cycle; a capture SHALL be requested in cycle N when event_in=1 and prev_event=0.
REQ-013 A capture in cycle N SHALL store the value of count sampled in cycle N, unmodified, in full Width.
REQ-014 A pop SHALL occur in a cycle where out_valid=1 and out_ready=1.
REQ-015 out_valid SHALL equal (level != 0), registered; no combinational path from event_in or count to out_valid or out_data.
REQ-016 Latency: a capture in cycle N into an empty FIFO SHALL appear as out_valid=1 with its value on out_data at cycle N+1.
REQ-017 Entries SHALL be delivered in capture order (FIFO).
REQ-018 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable.
REQ-019 out_data SHALL read 0 whenever out_valid=0.
REQ-020 Push without pop SHALL increment level; pop without push SHALL decrement it; push and pop together SHALL leave it unchanged.
REQ-021 Full (level=Depth) with capture and simultaneous pop: the pop SHALL complete, the capture SHALL be stored, and overflow SHALL NOT be set.
REQ-022 Full with capture and no pop: the capture SHALL be dropped, the contents SHALL be unchanged, and overflow SHALL be set to 1.
REQ-023 Empty with capture: the capture SHALL be stored, and no pop SHALL occur that cycle, whatever the value of out_ready.
REQ-024 overflow SHALL remain 1 until reset; there is no other clear path.
REQ-025 The read and write pointers SHALL wrap modulo Depth with no gap or duplicate entry.
REQ-026 A continuous high level on event_in SHALL produce exactly one capture.

Reset
REQ-027 When reset=1 at a rising edge: level=0, out_valid=0, out_data=0, overflow=0, both pointers=0, and prev_event=1.
REQ-028 Reset SHALL take priority over a simultaneous capture or pop; both SHALL be discarded.
REQ-029 Because prev_event resets to 1, event_in held high through reset SHALL NOT cause a capture until it is seen low and then high again.
REQ-030 Storage contents need not reset; they SHALL NOT be observable while out_valid=0.

Structure
REQ-031 Package count_capture_pkg SHALL hold DefaultWidth=8, DefaultDepth=4 and a level-width helper function.
REQ-032 The FIFO SHALL be one sub-module, sync_fifo, which owns the pointers, level and storage and is parameterised by Width and Depth.
REQ-033 count_capture SHALL contain only the edge detect, the overflow flag, the out_data masking and the sync_fifo instance.

Verification
REQ-034 Single capture: reset, count=0x2A, event_in pulse high for 1 cycle, out_ready=1 -> out_valid=1 next cycle with out_data=0x2A, then level=0.
REQ-035 Backpressure: out_ready=0, 4 event pulses at count=1,3,5,7 -> level=4, overflow=0; then out_ready=1 -> outputs 1,3,5,7 in order, one per cycle.
REQ-036 Overflow: FIFO full, out_ready=0, 5th pulse at count=9 -> overflow=1, level=4, 9 never output; overflow stays 1 after draining.
REQ-037 Full with simultaneous pop and push: level=4, out_ready=1, pulse at count=0x10 -> level=4, overflow=0, and 0x10 is output last.
REQ-038 Level hold and reset: event_in held high for 10 cycles -> exactly 1 capture; reset asserted mid-stream with event_in high -> all outputs 0 and no capture until event_in goes low and then high again.
REQ-039 Wrap: 3xDepth capture/drain cycles with the count input wrapping from 0xFF to 0x00 -> every value delivered exactly once and in order.
